fpu_issue_queue: RTL and testbench
==================================

Name: fpu_issue_queue

Overview:
- Sequential front end for the combinational bfloat16 `fpu`.
- Buffers operation requests (op, in1, in2) from a valid/ready producer in a small FIFO.
- Presents the FIFO head on the fpu input ports, then captures `fpu` out/overflow into a registered valid/ready result stage.
- Keeps a sticky overflow flag for software polling.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- OP_W, 4, operation code width.
- DATA_W, 16, bfloat16 operand/result width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  queue can accept a request.
- req_op_i  in  OP_W  operation code.
- req_in1_i  in  DATA_W  operand 1.
- req_in2_i  in  DATA_W  operand 2.
- fpu_op_o  out  OP_W  to fpu op_i (FIFO head).
- fpu_in1_o  out  DATA_W  to fpu in1_i.
- fpu_in2_o  out  DATA_W  to fpu in2_i.
- fpu_out_i  in  DATA_W  from fpu out_o.
- fpu_ovf_i  in  1  from fpu overflow_o.
- res_valid_o  out  1  result register valid.
- res_ready_i  in  1  consumer accepts result.
- res_data_o  out  DATA_W  registered result.
- res_ovf_o  out  1  registered overflow for this result.
- sticky_ovf_o  out  1  set by any issued overflow, held until cleared.
- ovf_clr_i  in  1  clears sticky_ovf_o.
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async, active-high): pointers, count_o, res_valid_o, res_data_o, res_ovf_o and sticky_ovf_o all go to 0.
- Reset mid-operation discards all queued and held results.
- FIFO pointers are $clog2(DEPTH)+1 bits wide, with the extra bit used as a wrap bit.
  - empty: pointers equal.
  - full: MSBs differ and the low bits are equal.
  - Pointers wrap naturally modulo 2*DEPTH.
- req_ready_o = !full, combinational from state only. There is no bypass: a full queue never accepts, even if it pops in the same cycle.
- push = req_valid_i & req_ready_o; the entry is written at the edge.
- fpu_* outputs = head entry when not empty; all zeros when empty.
- issue = !empty & (!res_valid_o | res_ready_i). On issue, at the edge:
  - capture fpu_out_i into res_data_o and fpu_ovf_i into res_ovf_o;
  - set res_valid_o = 1;
  - pop the head.
- If !issue and res_valid_o & res_ready_i: res_valid_o goes to 0. Data is held and is don't-care.
- While res_valid_o = 1 and res_ready_i = 0, res_data_o and res_ovf_o are stable.
- Push and issue in the same cycle: count_o unchanged, both pointers advance.
  - Legal at any occupancy except full (no push allowed).
  - Empty queue: no issue possible, so a push into an empty queue must not be issued in the same cycle.
- Latency: request accepted at edge N → fpu inputs valid in cycle N+1 → res_valid_o = 1 in cycle N+2 if the output is free.
- Throughput: 1 result per cycle with res_ready_i held high.
- sticky_ovf_o: next = (sticky & !ovf_clr_i) | (issue & fpu_ovf_i). A set in the same cycle as a clear wins.
- Operation codes are passed through unchecked; decode is owned by the fpu.

Decomposition:
- data_type_pkg gains:
  - BF16_W = 16 and OP_W = 4;
  - packed struct fpu_req_t {op, in1, in2} (36 bits).
  - The queue stores fpu_req_t.
- One sub-module: fpu_req_fifo, a generic DEPTH-entry synchronous FIFO of fpu_req_t.
  - Provides push/pop/empty/full/count and a head output.
  - Async active-high reset.
- Issue/result logic stays in fpu_issue_queue.
- Benches instantiate fpu_issue_queue connected to the real fpu.

Test Plan:
- Single request: ADD 0x3F80 + 0x4000, res_ready_i = 1 → res_valid_o high exactly 2 cycles after acceptance; res_data_o = 0x4040, res_ovf_o = 0; count_o back to 0.
- Fill: hold res_ready_i = 0 and push 6 MUL 0x3F80 × 0x4000 → 1 request issues into the result register, DEPTH = 4 queue; req_ready_o drops when count_o = 4; results stay 0x4000 and stable under backpressure.
- Drain/stream: continuous pushes with res_ready_i = 1 → one result per cycle, in order, no drops or duplicates.
  - Include a full-pointer wrap: at least 10 entries through DEPTH = 4.
- Simultaneous push + issue at count_o = 2 → count_o stays 2 and ordering is preserved.
- Overflow: MUL 0x7F00 × 0x7F00 → res_ovf_o = 1 and sticky_ovf_o = 1.
  - Assert ovf_clr_i in the same cycle as a second overflowing issue → sticky stays 1.
  - Assert ovf_clr_i alone → 0 next cycle.
- Reset mid-operation with 3 entries queued and res_valid_o = 1 → immediately (async): count_o = 0, res_valid_o = 0, sticky_ovf_o = 0, req_ready_o = 1.

Source files
------------

// File: rtl/data_type_pkg.sv
// Shared data types for the bfloat16 FPU slice: widths and the queued request record.
package data_type_pkg;

  localparam int unsigned BF16_W = 16;
  localparam int unsigned OP_W   = 4;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [BF16_W-1:0] in1;
    logic [BF16_W-1:0] in2;
  } fpu_req_t;

endpackage

// File: rtl/fpu_req_fifo.sv
// Synchronous DEPTH-entry FIFO of fpu_req_t with wrap-bit pointers and a head output.
module fpu_req_fifo
  import data_type_pkg::fpu_req_t;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fpu_req_t               wdata,
  input  logic                   pop,
  output fpu_req_t               head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;
  fpu_req_t    mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Pointer difference modulo 2*DEPTH is the occupancy, including DEPTH when full.
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fpu_issue_queue.sv
// Sequential front end for the combinational bfloat16 fpu: request FIFO, issue to the
// fpu, registered valid/ready result stage and a sticky overflow flag.
module fpu_issue_queue
  import data_type_pkg::fpu_req_t;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned DATA_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [OP_W-1:0]        req_op_i,
  input  logic [DATA_W-1:0]      req_in1_i,
  input  logic [DATA_W-1:0]      req_in2_i,
  output logic [OP_W-1:0]        fpu_op_o,
  output logic [DATA_W-1:0]      fpu_in1_o,
  output logic [DATA_W-1:0]      fpu_in2_o,
  input  logic [DATA_W-1:0]      fpu_out_i,
  input  logic                   fpu_ovf_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [DATA_W-1:0]      res_data_o,
  output logic                   res_ovf_o,
  output logic                   sticky_ovf_o,
  input  logic                   ovf_clr_i,
  output logic [$clog2(DEPTH):0] count_o
);

  fpu_req_t wr_req;
  fpu_req_t head;
  logic     empty;
  logic     full;
  logic     push;
  logic     issue;

  assign wr_req      = {req_op_i, req_in1_i, req_in2_i};
  // No bypass: readiness depends on stored occupancy only.
  assign req_ready_o = !full;
  assign push        = req_valid_i && req_ready_o;
  assign issue       = !empty && (!res_valid_o || res_ready_i);

  fpu_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (wr_req),
    .pop   (issue),
    .head  (head),
    .empty (empty),
    .full  (full),
    .count (count_o)
  );

  always_comb begin
    fpu_op_o  = '0;
    fpu_in1_o = '0;
    fpu_in2_o = '0;
    if (!empty) begin
      fpu_op_o  = head.op;
      fpu_in1_o = head.in1;
      fpu_in2_o = head.in2;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_o  <= 1'b0;
      res_data_o   <= '0;
      res_ovf_o    <= 1'b0;
      sticky_ovf_o <= 1'b0;
    end else begin
      if (issue) begin
        res_valid_o <= 1'b1;
        res_data_o  <= fpu_out_i;
        res_ovf_o   <= fpu_ovf_i;
      end else if (res_ready_i) begin
        res_valid_o <= 1'b0;
      end
      // A new overflow on issue outranks a simultaneous clear.
      sticky_ovf_o <= (sticky_ovf_o && !ovf_clr_i) || (issue && fpu_ovf_i);
    end
  end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Self-checking bench for fpu_issue_queue with a behavioural bfloat16 fpu stand-in.
module tb_fpu_issue_queue;
  import data_type_pkg::fpu_req_t;

  localparam int unsigned DEPTH = 4;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [15:0] req_in1 = '0;
  logic [15:0] req_in2 = '0;
  logic [3:0]  fpu_op;
  logic [15:0] fpu_in1;
  logic [15:0] fpu_in2;
  logic [15:0] fpu_out;
  logic        fpu_ovf;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_ovf;
  logic        sticky_ovf;
  logic        ovf_clr = 1'b0;
  logic [2:0]  count;
  logic [16:0] stub_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Simplified bfloat16 unit: {overflow, result}. Op 0 add, op 1 multiply, else xor.
  function automatic logic [16:0] fpu_model(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [15:0] x, y, big, sml, diff, p;
    logic [16:0] sum;
    logic [7:0]  ma, mb;
    logic [6:0]  m;
    logic        s;
    int          e, d;
    if (op == OP_MUL) begin
      s = a[15] ^ b[15];
      if (a[14:7] == 0 || b[14:7] == 0) return {1'b0, s, 15'h0};
      ma = {1'b1, a[6:0]};
      mb = {1'b1, b[6:0]};
      p  = 16'(ma * mb);
      e  = int'(a[14:7]) + int'(b[14:7]) - 127;
      if (p[15]) begin m = p[14:8]; e++; end
      else m = p[13:7];
    end else if (op == OP_ADD) begin
      if (a[14:7] == 0) return {1'b0, b};
      if (b[14:7] == 0) return {1'b0, a};
      x = a; y = b;
      if (a[14:0] < b[14:0]) begin x = b; y = a; end
      s   = x[15];
      e   = int'(x[14:7]);
      d   = int'(x[14:7]) - int'(y[14:7]);
      big = {1'b1, x[6:0], 8'h00};
      sml = (d > 15) ? 16'h0 : ({1'b1, y[6:0], 8'h00} >> d);
      if (x[15] == y[15]) begin
        sum = {1'b0, big} + {1'b0, sml};
        if (sum[16]) begin m = sum[15:9]; e++; end
        else m = sum[14:8];
      end else begin
        diff = big - sml;
        if (diff == 0) return 17'h0;
        for (int i = 0; i < 16; i++)
          if (!diff[15]) begin diff = diff << 1; e--; end
        m = diff[14:8];
      end
    end else begin
      return {1'b0, a ^ b};
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 7'h0};
    if (e <= 0) return {1'b0, s, 15'h0};
    return {1'b0, s, 8'(e), m};
  endfunction

  assign stub_r  = fpu_model(fpu_op, fpu_in1, fpu_in2);
  assign fpu_out = stub_r[15:0];
  assign fpu_ovf = stub_r[16];

  fpu_issue_queue #(
    .DEPTH  (DEPTH),
    .OP_W   (4),
    .DATA_W (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_in1_i    (req_in1),
    .req_in2_i    (req_in2),
    .fpu_op_o     (fpu_op),
    .fpu_in1_o    (fpu_in1),
    .fpu_in2_o    (fpu_in2),
    .fpu_out_i    (fpu_out),
    .fpu_ovf_i    (fpu_ovf),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data),
    .res_ovf_o    (res_ovf),
    .sticky_ovf_o (sticky_ovf),
    .ovf_clr_i    (ovf_clr),
    .count_o      (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an ordered queue of pending requests plus the result slot.
  fpu_req_t    mq[$];
  logic        m_rv = 1'b0;
  logic [15:0] m_data = '0;
  logic        m_ovf = 1'b0;
  logic        m_sticky = 1'b0;
  logic        m_acc, m_iss;
  logic [16:0] m_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_rv = 1'b0; m_data = '0; m_ovf = 1'b0; m_sticky = 1'b0;
    end else begin
      m_acc = req_valid && (mq.size() < DEPTH);
      m_iss = (mq.size() > 0) && (!m_rv || res_ready);
      m_r   = '0;
      if (m_iss) m_r = fpu_model(mq[0].op, mq[0].in1, mq[0].in2);
      m_sticky = (m_sticky && !ovf_clr) || (m_iss && m_r[16]);
      if (m_iss) begin
        m_rv = 1'b1; m_data = m_r[15:0]; m_ovf = m_r[16];
        void'(mq.pop_front());
      end else if (m_rv && res_ready) begin
        m_rv = 1'b0;
      end
      if (m_acc) mq.push_back({req_op, req_in1, req_in2});
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
      chk("count", 32'(count), 32'(mq.size()));
      chk("fpu_op", 32'(fpu_op), (mq.size() > 0) ? 32'(mq[0].op) : 32'h0);
      chk("fpu_in1", 32'(fpu_in1), (mq.size() > 0) ? 32'(mq[0].in1) : 32'h0);
      chk("fpu_in2", 32'(fpu_in2), (mq.size() > 0) ? 32'(mq[0].in2) : 32'h0);
      chk("res_valid", 32'(res_valid), 32'(m_rv));
      chk("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
      if (m_rv) begin
        chk("res_data", 32'(res_data), 32'(m_data));
        chk("res_ovf", 32'(res_ovf), 32'(m_ovf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    req_valid = v; req_op = op; req_in1 = a; req_in2 = b;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_res_valid", 32'(res_valid), 32'h0);
    chk("reset_sticky", 32'(sticky_ovf), 32'h0);
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    chk("reset_res_data", 32'(res_data), 32'h0);
    chk("reset_fpu_op", 32'(fpu_op), 32'h0);

    // Single add: result visible two edges after acceptance.
    res_ready = 1'b1;
    drive(1'b1, OP_ADD, 16'h3F80, 16'h4000);
    step();
    drive(1'b0, OP_ADD, 16'h0, 16'h0);
    chk("single_lat1_valid", 32'(res_valid), 32'h0);
    chk("single_fpu_in1", 32'(fpu_in1), 32'h3F80);
    step();
    chk("single_valid", 32'(res_valid), 32'h1);
    chk("single_data", 32'(res_data), 32'h4040);
    chk("single_ovf", 32'(res_ovf), 32'h0);
    chk("single_count", 32'(count), 32'h0);
    step();

    // Fill under backpressure.
    res_ready = 1'b0;
    drive(1'b1, OP_MUL, 16'h3F80, 16'h4000);
    repeat (6) step();
    drive(1'b0, OP_MUL, 16'h0, 16'h0);
    chk("fill_count", 32'(count), 32'h4);
    chk("fill_ready", 32'(req_ready), 32'h0);
    chk("fill_data", 32'(res_data), 32'h4000);
    repeat (3) step();
    chk("hold_data", 32'(res_data), 32'h4000);
    chk("hold_valid", 32'(res_valid), 32'h1);

    // Drain to two, then push and issue together.
    res_ready = 1'b1;
    repeat (2) step();
    chk("drain_count", 32'(count), 32'h2);
    drive(1'b1, OP_ADD, 16'h3F80, 16'h4000);
    step();
    drive(1'b0, OP_ADD, 16'h0, 16'h0);
    chk("simul_count", 32'(count), 32'h2);
    repeat (3) step();
    chk("simul_order_data", 32'(res_data), 32'h4040);
    repeat (2) step();

    // Overflow and sticky flag behaviour.
    drive(1'b1, OP_MUL, 16'h7F00, 16'h7F00);
    step();
    drive(1'b0, OP_MUL, 16'h0, 16'h0);
    step();
    chk("ovf_res", 32'(res_ovf), 32'h1);
    chk("ovf_sticky", 32'(sticky_ovf), 32'h1);
    chk("ovf_data", 32'(res_data), 32'h7F80);
    drive(1'b1, OP_MUL, 16'h7F00, 16'h7F00);
    step();
    drive(1'b0, OP_MUL, 16'h0, 16'h0);
    ovf_clr = 1'b1;
    step();
    chk("ovf_set_beats_clr", 32'(sticky_ovf), 32'h1);
    step();
    ovf_clr = 1'b0;
    chk("ovf_clear", 32'(sticky_ovf), 32'h0);

    // Continuous stream, wraps pointers several times.
    drive(1'b1, OP_MUL, 16'h3F80, 16'h4000);
    for (int i = 0; i < 20; i++) begin
      req_in1 = 16'($urandom_range(16'h3F00, 16'h40FF));
      req_in2 = 16'($urandom_range(16'h3F00, 16'h40FF));
      step();
    end

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_op    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(2, 15))
                                              : 4'($urandom_range(0, 1));
      req_in1   = 16'($urandom);
      req_in2   = 16'($urandom);
      res_ready = ($urandom_range(0, 9) < 6);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      step();
    end

    // Reset with three queued and a held result.
    drive(1'b0, OP_ADD, 16'h0, 16'h0);
    ovf_clr = 1'b0;
    res_ready = 1'b1;
    repeat (8) step();
    res_ready = 1'b0;
    drive(1'b1, OP_MUL, 16'h7F00, 16'h7F00);
    repeat (4) step();
    drive(1'b0, OP_ADD, 16'h0, 16'h0);
    chk("pre_rst_count", 32'(count), 32'h3);
    chk("pre_rst_valid", 32'(res_valid), 32'h1);
    chk("pre_rst_sticky", 32'(sticky_ovf), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_valid", 32'(res_valid), 32'h0);
    chk("rst_sticky", 32'(sticky_ovf), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    step();
    rst = 1'b0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
